// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared USB transmit-path types and constants
package usb_tx_pkg;

  typedef logic [7:0] byte_t;

  localparam int TX_FIFO_DEPTH_DEFAULT = 64;

endpackage

// File: rtl/tx_fifo_ctrl.sv
// rtl/tx_fifo_ctrl.sv - tx_fifo pointer, occupancy count and empty/full flag control
module tx_fifo_ctrl #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          i_wr_req,
  input  logic          i_rd_req,
  input  logic          i_flush,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_ptr,
  output logic [AW-1:0] o_rd_ptr,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_empty, r_full;

  logic          w_do_wr, w_do_rd;
  logic [AW-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_empty_nxt, w_full_nxt;

  // A push while full is accepted only alongside a pop: it lands in the slot being freed.
  assign w_do_wr = i_wr_req & (~r_full | i_rd_req);
  assign w_do_rd = i_rd_req & ~r_empty;
  assign o_wr_en = w_do_wr & ~i_flush;

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    w_empty_nxt  = r_empty;
    w_full_nxt   = r_full;
    if (i_flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_count_nxt  = '0;
      w_empty_nxt  = 1'b1;
      w_full_nxt   = 1'b0;
    end else begin
      if (w_do_wr) w_wr_ptr_nxt = r_wr_ptr + AW'(1);
      if (w_do_rd) w_rd_ptr_nxt = r_rd_ptr + AW'(1);
      w_count_nxt = r_count + CW'(w_do_wr) - CW'(w_do_rd);
      w_empty_nxt = (w_count_nxt == '0);
      w_full_nxt  = (w_count_nxt == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_empty  <= w_empty_nxt;
      r_full   <= w_full_nxt;
    end
  end

  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;
  assign o_empty  = r_empty;
  assign o_full   = r_full;

endmodule

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - first-word fall-through byte FIFO for USB transmit; optional TX_FIFO_FLUSH_EN adds flush
module tx_fifo
  import usb_tx_pkg::*;
#(
  parameter  int DEPTH = TX_FIFO_DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          w_enable,
  input  byte_t         w_data,
  input  logic          r_enable,
`ifdef TX_FIFO_FLUSH_EN
  input  logic          flush,
`endif
  output byte_t         r_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  byte_t         r_mem [DEPTH];
  logic          w_flush;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_ptr, w_rd_ptr;

`ifdef TX_FIFO_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  tx_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk      (clk),
    .n_rst    (n_rst),
    .i_wr_req (w_enable),
    .i_rd_req (r_enable),
    .i_flush  (w_flush),
    .o_wr_en  (w_wr_en),
    .o_wr_ptr (w_wr_ptr),
    .o_rd_ptr (w_rd_ptr),
    .o_count  (count),
    .o_empty  (empty),
    .o_full   (full)
  );

  // Storage is not reset; the pointers and empty flag alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_ptr] <= w_data;
  end

  assign r_data = empty ? 8'h00 : r_mem[w_rd_ptr];

endmodule
